// File: rtl/compare_serial.sv
// Purpose : serial magnitude comparator, two N-bit operands streamed D bits per valid cycle -> g/e/l.
// Latency : done pulses the cycle after the last digit is sampled; start is accepted in IDLE/DONE only.
// Backpress: none; in_valid_i gaps simply stall the digit counter, digits outside RUN are dropped.
//
// Ports:
//   clk, rst          clock / synchronous active-high reset
//   start_i           begin a new comparison (ignored while busy)
//   in_valid_i        x_i/y_i carry a digit this cycle
//   x_i, y_i          current D-bit digits of the two operands
//   busy_o            high while digits are being consumed
//   done_o            one-cycle pulse, g/e/l final
//   g_o, e_o, l_o     x > y, x == y, x < y (exactly one is high, all registered)
module compare_serial #(
    parameter int N         = 64,
    parameter int D         = 2,
    parameter int SIGNED    = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         in_valid_i,
    input  logic [D-1:0] x_i,
    input  logic [D-1:0] y_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         g_o,
    output logic         e_o,
    output logic         l_o
);

    localparam int C  = N / D;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(C - 1);
    // The digit carrying the operand sign bits.
    localparam logic [CW-1:0] SIGN_IDX = (MSB_FIRST != 0) ? '0 : CW'(C - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q, done_q;
    logic          g_q, e_q, l_q;

    logic [D-1:0]  xs, ys;
    logic          sign_flip;
    logic          dgt, dlt;
    logic          g_d, e_d, l_d;
    logic [CW-1:0] cnt_d;

    // Digit relation and result update for the digit on the inputs this cycle.
    always_comb begin
        // Flipping the top bit of the sign digit maps two's-complement order
        // onto unsigned order, so one unsigned comparator serves both modes.
        sign_flip = (SIGNED != 0) && (cnt_q == SIGN_IDX);
        xs        = x_i;
        ys        = y_i;
        xs[D-1]   = x_i[D-1] ^ sign_flip;
        ys[D-1]   = y_i[D-1] ^ sign_flip;
        dgt       = (xs > ys);
        dlt       = (xs < ys);

        g_d   = g_q;
        e_d   = e_q;
        l_d   = l_q;
        cnt_d = cnt_q + 1'b1;

        if (MSB_FIRST != 0) begin
            // First unequal digit from the top decides; later digits are ignored.
            if (e_q && (dgt || dlt)) begin
                g_d = dgt;
                l_d = dlt;
                e_d = 1'b0;
            end
        end else begin
            // Each unequal digit is more significant than all before it, so it overrides.
            if (dgt || dlt) begin
                g_d = dgt;
                l_d = dlt;
                e_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            g_q     <= 1'b0;
            e_q     <= 1'b1;
            l_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    // A digit presented together with start is dropped.
                    if (start_i) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        g_q     <= 1'b0;
                        e_q     <= 1'b1;
                        l_q     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (in_valid_i) begin
                        g_q   <= g_d;
                        e_q   <= e_d;
                        l_q   <= l_d;
                        cnt_q <= cnt_d;
                        if (cnt_q == LAST_IDX) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign g_o    = g_q;
    assign e_o    = e_q;
    assign l_o    = l_q;

endmodule
